// File: rtl/temp_display_ctrl_pkg.sv
// Shared constants and FSM encoding for the temperature display controller.
// Digit codes, conversion iteration count and datapath widths live here.
package temp_display_ctrl_pkg;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam int CONV_ITER = 12;
  localparam int BIN_W     = 12;
  localparam int BCD_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALE,
    ST_CONV,
    ST_FORMAT
  } state_e;

endpackage

// File: rtl/temp_display_ctrl_bin_to_bcd12.sv
// Serial double-dabble engine: 12-bit binary to four BCD digits, one
// shift-add-3 iteration per clock. done is high during the final iteration.
module bin_to_bcd12
  import temp_display_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             done
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last;
  // Top digit keeps only 3 bits: its MSB is shifted out of the register.
  logic [BCD_W-2:0] adj;

  assign last = busy_q && (cnt_q == 4'(CONV_ITER - 1));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                : bcd_q[4*i +: 4];
    end
    adj[14:12] = (bcd_q[15:12] >= 4'd5) ? 3'(bcd_q[15:12] + 4'd3) : bcd_q[14:12];

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = bin_in;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d  = {adj, bin_q[BIN_W-1]};
      bin_d  = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d  = last ? 4'd0 : cnt_q + 4'd1;
      busy_d = !last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign bcd_out = bcd_q;
  assign done    = last;

endmodule

// File: rtl/temp_display_ctrl.sv
// TMP121 raw word to four 7-segment digit codes (tenths, units, tens, hundreds).
// Define TEMP_DISP_ROUND_EN to round half up when scaling; otherwise truncate.
module temp_display_ctrl
  import temp_display_ctrl_pkg::*;
#(
  parameter int RAW_W     = 13,
  parameter int FRAC_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW_W-1:0] temp_raw,
  output logic [3:0]       dout0,
  output logic [3:0]       dout1,
  output logic [3:0]       dout2,
  output logic [3:0]       dout3,
  output logic             done,
  output logic             ovf
);

  localparam int PROD_W = RAW_W + 4;

  state_e           state_q, state_d;
  logic [RAW_W-1:0] raw_q, raw_d;
  logic [15:0]      dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             neg;
  logic [RAW_W-1:0] mag;
  logic [PROD_W-1:0] prod, scaled;
  logic [BIN_W-1:0] t_bin;
  logic             bcd_start, bcd_done;
  logic [BCD_W-1:0] bcd;
  logic             blank3, blank2;
  logic [15:0]      fmt_dout;
  logic             fmt_ovf;

  // Magnitude in RAW_W bits: -4096 wraps to 4096 as unsigned, as intended.
  always_comb begin
    neg  = raw_q[RAW_W-1];
    mag  = neg ? (~raw_q + RAW_W'(1)) : raw_q;
    prod = (PROD_W'(mag) << 3) + (PROD_W'(mag) << 1);
`ifdef TEMP_DISP_ROUND_EN
    scaled = prod + PROD_W'(1 << (FRAC_BITS - 1));
`else
    scaled = prod;
`endif
    t_bin = BIN_W'(scaled >> FRAC_BITS);
  end

  bin_to_bcd12 u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (bcd_start),
    .bin_in  (t_bin),
    .bcd_out (bcd),
    .done    (bcd_done)
  );

  // Sign goes in the blank slot just left of the first shown digit.
  always_comb begin
    blank3   = (bcd[15:12] == 4'd0);
    blank2   = blank3 && (bcd[11:8] == 4'd0);
    fmt_dout = {blank3 ? DIG_BLANK : bcd[15:12],
                blank2 ? DIG_BLANK : bcd[11:8],
                bcd[7:0]};
    fmt_ovf  = 1'b0;
    if (neg && (bcd != '0)) begin
      if (blank2) begin
        fmt_dout[11:8] = DIG_DASH;
      end else if (blank3) begin
        fmt_dout[15:12] = DIG_DASH;
      end else begin
        fmt_ovf  = 1'b1;
        fmt_dout = {4{DIG_DASH}};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    raw_d     = raw_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    bcd_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          raw_d   = temp_raw;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        bcd_start = 1'b1;
        state_d   = ST_CONV;
      end
      ST_CONV: begin
        if (bcd_done) state_d = ST_FORMAT;
      end
      ST_FORMAT: begin
        dout_d  = fmt_dout;
        ovf_d   = fmt_ovf;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      raw_q   <= '0;
      dout_q  <= {4{DIG_BLANK}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign dout0    = dout_q[3:0];
  assign dout1    = dout_q[7:4];
  assign dout2    = dout_q[11:8];
  assign dout3    = dout_q[15:12];
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Self-checking bench for temp_display_ctrl: vector table plus reset and
// busy-input sequences. Expectations follow TEMP_DISP_ROUND_EN if defined.
module tb_temp_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] temp_raw;
  logic [3:0]  dout0, dout1, dout2, dout3;
  logic        done;
  logic        ovf;
  logic [15:0] dout_all;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          raw;
    logic [15:0] exp;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  assign dout_all = {dout3, dout2, dout1, dout0};

  temp_display_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .temp_raw (temp_raw),
    .dout0    (dout0),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .done     (done),
    .ovf      (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one sample in the current cycle (may be the previous done cycle)
  // and returns the number of clock edges from accept to the done pulse.
  task automatic send(input int raw, output int lat);
    @(negedge clk);
    temp_raw = 13'(raw);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          n;
    logic [15:0] prev;
    logic        prev_ovf;
    logic        glitch;

    vecs[0]  = '{400,   16'hF250, 1'b0};
    vecs[1]  = '{2400,  16'h1500, 1'b0};
    vecs[2]  = '{-880,  16'hA550, 1'b0};
`ifdef TEMP_DISP_ROUND_EN
    vecs[3]  = '{-1,    16'hFA01, 1'b0};
    vecs[10] = '{3,     16'hFF02, 1'b0};
    vecs[11] = '{1,     16'hFF01, 1'b0};
`else
    vecs[3]  = '{-1,    16'hFF00, 1'b0};
    vecs[10] = '{3,     16'hFF01, 1'b0};
    vecs[11] = '{1,     16'hFF00, 1'b0};
`endif
    vecs[4]  = '{-1600, 16'hAAAA, 1'b1};
    vecs[5]  = '{0,     16'hFF00, 1'b0};
    vecs[6]  = '{4095,  16'h2559, 1'b0};
    vecs[7]  = '{-4096, 16'hAAAA, 1'b1};
    vecs[8]  = '{-24,   16'hFA15, 1'b0};
    vecs[9]  = '{-160,  16'hA100, 1'b0};
    vecs[12] = '{-8,    16'hFA05, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    temp_raw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_dout", dout_all, 16'hFFFF);
    check("reset_done", done, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    // Back-to-back: each sample is offered in the previous done cycle.
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].raw, lat);
      check($sformatf("latency[%0d]", i), lat, 14);
      check($sformatf("dout[%0d]", i), dout_all, vecs[i].exp);
      check($sformatf("ovf[%0d]", i), ovf, vecs[i].exp_ovf);
      check($sformatf("in_ready_at_done[%0d]", i), in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    check("done_single_pulse", done, 1'b0);

    // in_valid pulses while busy must be ignored; outputs hold until done.
    prev     = dout_all;
    prev_ovf = ovf;
    glitch   = 1'b0;
    @(negedge clk);
    temp_raw = 13'(400);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2 || k == 5 || k == 8) begin
        in_valid = 1'b1;
        temp_raw = 13'(-1600);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (dout_all !== prev || ovf !== prev_ovf) glitch = 1'b1;
    end
    in_valid = 1'b0;
    check("busy_latency", lat, 14);
    check("busy_dout", dout_all, 16'hF250);
    check("busy_ovf", ovf, 1'b0);
    check("busy_outputs_held", glitch, 1'b0);
    count_done(30, n);
    check("busy_no_queued_sample", n, 0);

    // Reset six cycles into a conversion discards it.
    @(negedge clk);
    temp_raw = 13'(-880);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_dout", dout_all, 16'hFFFF);
    check("midreset_done", done, 1'b0);
    check("midreset_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_dout_after", dout_all, 16'hFFFF);
    count_done(30, n);
    check("midreset_no_done", n, 0);

    send(2400, lat);
    check("recover_latency", lat, 14);
    check("recover_dout", dout_all, 16'h1500);
    check("recover_ovf", ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
